// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types for the keypad scanner: scan FSM states and default key-index width.
package keypad_matrix_scanner_pkg;

    typedef enum logic {
        ST_DRIVE  = 1'b0,
        ST_SAMPLE = 1'b1
    } scan_state_t;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int KEY_W    = $clog2(DEF_ROWS * DEF_COLS);

    // Never returns 0, so single-entry counters and indices still get one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_sync.sv
// Two-flop synchronizer for the raw row sense lines; 2-cycle latency, no backpressure.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning key matrix reader with whole-frame debounce and a lowest-index press event.
// key_map/key_valid update one cycle after the frame-end sample; no backpressure (free-running).
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ROWS-1:0]                      row_in,
    output logic [COLS-1:0]                      col_out,
    output logic [ROWS*COLS-1:0]                 key_map,
    output logic                                 key_valid,
    output logic [clog2_min1(ROWS*COLS)-1:0]     key_code,
    output logic                                 key_held
);

    localparam int N    = ROWS * COLS;
    localparam int KW   = clog2_min1(N);
    localparam int IW   = clog2_min1(COLS);
    localparam int CNTW = clog2_min1(SCAN_DIV);
    localparam int SW   = clog2_min1(DEBOUNCE_FRAMES + 1);

    logic [ROWS-1:0] rows_sync;

    sync_2ff #(.W(ROWS)) u_row_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (row_in),
        .q     (rows_sync)
    );

    scan_state_t     state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    raw_q, raw_d;
    logic [N-1:0]    prev_q, prev_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic [N-1:0]    key_map_q, key_map_d;
    logic            key_valid_q, key_valid_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_held_q, key_held_d;
    logic [N-1:0]    new_keys;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        raw_d       = raw_q;
        prev_d      = prev_q;
        stable_d    = stable_q;
        key_map_d   = key_map_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        new_keys    = '0;

        case (state_q)
            ST_DRIVE: begin
                cnt_d = cnt_q + CNTW'(1);
                // SAMPLE is the last cycle of the dwell, so leave DRIVE one count early.
                if (cnt_q == CNTW'(SCAN_DIV - 2)) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                raw_d[idx_q*ROWS +: ROWS] = rows_sync;
                cnt_d   = '0;
                idx_d   = (idx_q == IW'(COLS - 1)) ? '0 : idx_q + IW'(1);
                state_d = ST_DRIVE;
                if (idx_q == IW'(COLS - 1)) begin
                    if (raw_d == prev_q)
                        stable_d = (stable_q == SW'(DEBOUNCE_FRAMES)) ? stable_q : stable_q + SW'(1);
                    else
                        stable_d = SW'(1);
                    prev_d = raw_d;
                    if (stable_d == SW'(DEBOUNCE_FRAMES) && raw_d != key_map_q) begin
                        key_map_d = raw_d;
                        new_keys  = raw_d & ~key_map_q;
                        if (|new_keys) begin
                            key_valid_d = 1'b1;
                            // Descending scan so the lowest set index wins.
                            for (int i = N - 1; i >= 0; i--)
                                if (new_keys[i]) key_code_d = KW'(i);
                        end
                    end
                end
            end
            default: state_d = ST_DRIVE;
        endcase

        key_held_d = |key_map_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_DRIVE;
            idx_q       <= '0;
            cnt_q       <= '0;
            raw_q       <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            key_map_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            raw_q       <= raw_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            key_map_q   <= key_map_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_out   = COLS'(1) << idx_q;
    assign key_map   = key_map_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule
